draw_scheduler: RTL

Sequencer and pixel-port arbiter for the 160x120 VGA drawing system. On one `start` it runs up to three drawing engines (fillscreen, circle, Reuleaux triangle) in fixed index order, using each engine's start/done handshake. While an engine runs, its pixel stream is forwarded to the single `vga_adapter` plot port. The block sits between the task toplevel and the engines, so the toplevel drives one start and watches one done.

---
 rtl/draw_scheduler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
// draw_scheduler: runs up to three drawing engines in index order from one
// start request and forwards the active engine's pixels to the VGA plot port.
// Optional clipping to X_MAX x Y_MAX is compiled in with DRAW_SCHED_CLIP_EN.
//
// Handshakes: start/done is a level pair. start is held high until done is
// seen, and done stays high until start falls. eng_start[i]/eng_done[i] work
// the same way. eng_start[i] is held until eng_done[i] is seen, and the next
// engine is only selected after eng_done[i] has fallen again.
module draw_scheduler #(
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  en_mask,
  output logic        done,
  output logic        busy,
  output logic [2:0]  eng_start,
  input  logic [2:0]  eng_done,
  input  logic [23:0] eng_x,
  input  logic [20:0] eng_y,
  input  logic [8:0]  eng_colour,
  input  logic [2:0]  eng_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [15:0] plot_count,
  output logic [15:0] clip_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_RUN     = 3'd2,
    S_RELEASE = 3'd3,
    S_FIN     = 3'd4
  } state_t;

`ifdef DRAW_SCHED_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  state_t     state, state_next;
  // pending holds the masked-in engines not yet run; the lowest set bit is
  // always above the cursor, so it stands in for the "index > cursor" search.
  logic [2:0] pending, pending_next;
  logic [1:0] cur, cur_next;
  logic       accept;

  logic [7:0] act_x;
  logic [6:0] act_y;
  logic [2:0] act_c;
  logic       act_plot, act_done;
  logic       cand, out_of_range, clipped, fwd;

  assign state_dbg = state;

  // Select the x/y/colour/plot/done lines of the engine at the cursor.
  always_comb begin
    act_x    = eng_x[7:0];
    act_y    = eng_y[6:0];
    act_c    = eng_colour[2:0];
    act_plot = eng_plot[0];
    act_done = eng_done[0];
    case (cur)
      2'd1: begin
        act_x    = eng_x[15:8];
        act_y    = eng_y[13:7];
        act_c    = eng_colour[5:3];
        act_plot = eng_plot[1];
        act_done = eng_done[1];
      end
      2'd2: begin
        act_x    = eng_x[23:16];
        act_y    = eng_y[20:14];
        act_c    = eng_colour[8:6];
        act_plot = eng_plot[2];
        act_done = eng_done[2];
      end
      default: ;
    endcase
  end

  assign cand         = (state == S_RUN) && act_plot;
  assign out_of_range = ({1'b0, act_x} >= 9'(X_MAX)) || ({1'b0, act_y} >= 8'(Y_MAX));
  assign clipped      = CLIP_EN && out_of_range;
  assign fwd          = cand && !clipped;

  // Next-state logic for the engine sequencer.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    cur_next     = cur;
    accept       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept       = 1'b1;
          pending_next = en_mask;
          state_next   = S_SELECT;
        end
      end
      S_SELECT: begin
        if (pending[0]) begin
          cur_next        = 2'd0;
          pending_next[0] = 1'b0;
          state_next      = S_RUN;
        end else if (pending[1]) begin
          cur_next        = 2'd1;
          pending_next[1] = 1'b0;
          state_next      = S_RUN;
        end else if (pending[2]) begin
          cur_next        = 2'd2;
          pending_next[2] = 1'b0;
          state_next      = S_RUN;
        end else begin
          state_next = S_FIN;
        end
      end
      S_RUN:     if (act_done) state_next = S_RELEASE;
      S_RELEASE: if (!act_done) state_next = S_SELECT;
      S_FIN:     if (!start) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pending <= 3'b000;
      cur     <= 2'd0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      cur     <= cur_next;
    end
  end

  // Registered control outputs; eng_start drops on the edge that sees done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      busy      <= 1'b0;
      eng_start <= 3'b000;
    end else begin
      done      <= (state == S_FIN) && start;
      eng_start <= (state == S_RUN && !act_done) ? 3'(3'b001 << cur) : 3'b000;
      if (accept)
        busy <= 1'b1;
      else if (state == S_FIN)
        busy <= 1'b0;
    end
  end

  // Pixel port: copy a forwarded pixel and pulse plot; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= fwd;
      if (fwd) begin
        vga_x      <= act_x;
        vga_y      <= act_y;
        vga_colour <= act_c;
      end
    end
  end

  // Saturating count of forwarded pixels, cleared on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      plot_count <= 16'd0;
    else if (accept)
      plot_count <= 16'd0;
    else if (fwd && plot_count != 16'hFFFF)
      plot_count <= plot_count + 16'd1;
  end

`ifdef DRAW_SCHED_CLIP_EN
  // Saturating count of clipped pixels, cleared on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clip_count <= 16'd0;
    else if (accept)
      clip_count <= 16'd0;
    else if (cand && clipped && clip_count != 16'hFFFF)
      clip_count <= clip_count + 16'd1;
  end
`else
  assign clip_count = 16'd0;
`endif

endmodule
